// File: rtl/fb_writer_if.sv
// fb_writer_if -- bundle of the pixel-request, fill-control and framebuffer
// write-port signals used by fb_writer.
//   Request side : req_valid, req_ready, req_x[9:0], req_y[8:0], req_color[7:0]
//   Fill control : fill_start, fill_color[7:0]
//   Status       : busy, err_oob
//   RAM write    : mem_addr[18:0], mem_data[7:0], mem_we
// The master modport is the requester (the bench or an upstream client); the
// slave modport is fb_writer itself.
interface fb_writer_if;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_x;
  logic [8:0]  req_y;
  logic [7:0]  req_color;
  logic        fill_start;
  logic [7:0]  fill_color;
  logic        busy;
  logic        err_oob;
  logic [18:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we;

  modport master (
    output req_valid, req_x, req_y, req_color, fill_start, fill_color,
    input  req_ready, busy, err_oob, mem_addr, mem_data, mem_we
  );

  modport slave (
    input  req_valid, req_x, req_y, req_color, fill_start, fill_color,
    output req_ready, busy, err_oob, mem_addr, mem_data, mem_we
  );
endinterface

// File: rtl/fb_writer.sv
// fb_writer -- framebuffer pixel writer with full-frame clear.
// Pixel requests are queued in a small FIFO, converted to a linear address
// (y*H_RES + x) in an address stage and written to the framebuffer RAM in a
// write stage, one pixel per cycle. A fill request drains queued pixels, then
// writes fill_color to every address 0..H_RES*V_RES-1.
// Ports:
//   clk  : system clock (also the framebuffer write-port clock)
//   rst  : synchronous active-high reset
//   bus  : fb_writer_if.slave -- request handshake, fill control, status and
//          framebuffer write port
module fb_writer #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  fb_writer_if.slave  bus
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [18:0] TOTAL   = 19'(H_RES * V_RES);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_FILL_WAIT, S_FILL} state_t;

  function automatic logic [18:0] pix_addr(input logic [9:0] x, input logic [8:0] y);
    return 19'(y) * 19'(H_RES) + 19'(x);
  endfunction

  function automatic logic out_of_range(input logic [9:0] x, input logic [8:0] y);
    return (32'(x) >= H_RES) || (32'(y) >= V_RES);
  endfunction

  state_t      r_state;
  logic [AW:0] r_wptr, r_rptr;
  logic [26:0] r_fifo [FIFO_DEPTH];
  logic [18:0] r_cnt;
  logic [7:0]  r_fill_color;

  logic        r_vld_p1, r_oob_p1;
  logic [18:0] r_addr_p1;
  logic [7:0]  r_color_p1;

  logic        r_we_p2, r_oob_p2;
  logic [18:0] r_addr_p2;
  logic [7:0]  r_data_p2;

  logic        w_empty, w_full, w_ready, w_push, w_pop;
  logic [26:0] w_head;
  logic [9:0]  w_x;
  logic [8:0]  w_y;
  logic [7:0]  w_c;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  // rst gates ready so nothing is accepted while the block is held in reset.
  assign w_ready = !rst && (r_state == S_IDLE) && !w_full;
  assign w_push  = bus.req_valid && w_ready;
  // Queued pixels keep draining in FILL_WAIT; the FIFO is always empty in FILL.
  assign w_pop   = !w_empty && (r_state != S_FILL);
  assign w_head  = r_fifo[r_rptr[AW-1:0]];
  assign {w_x, w_y, w_c} = w_head;

  assign bus.req_ready = w_ready;
  assign bus.busy      = (r_state != S_IDLE) || !w_empty || r_vld_p1 || r_we_p2 || r_oob_p2;
  assign bus.err_oob   = r_oob_p2;
  assign bus.mem_we    = r_we_p2;
  assign bus.mem_addr  = r_addr_p2;
  assign bus.mem_data  = r_data_p2;

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr[AW-1:0]] <= {bus.req_x, bus.req_y, bus.req_color};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_cnt     <= '0;
      r_vld_p1  <= 1'b0;
      r_oob_p1  <= 1'b0;
      r_we_p2   <= 1'b0;
      r_oob_p2  <= 1'b0;
      r_addr_p2 <= '0;
      r_data_p2 <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;

      // ---- p1: address stage (FIFO head -> linear address) ----
      r_vld_p1 <= w_pop;
      r_oob_p1 <= w_pop && out_of_range(w_x, w_y);
      if (w_pop) begin
        r_addr_p1  <= pix_addr(w_x, w_y);
        r_color_p1 <= w_c;
      end

      // ---- p2: write stage (RAM write port / drop report) ----
      r_we_p2  <= r_vld_p1 && !r_oob_p1;
      r_oob_p2 <= r_vld_p1 && r_oob_p1;
      if (r_vld_p1 && !r_oob_p1) begin
        r_addr_p2 <= r_addr_p1;
        r_data_p2 <= r_color_p1;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.fill_start) begin
            r_state      <= S_FILL_WAIT;
            r_fill_color <= bus.fill_color;
          end
        end
        S_FILL_WAIT: begin
          if (w_empty && !r_vld_p1) begin
            r_state <= S_FILL;
            r_cnt   <= '0;
          end
        end
        S_FILL: begin
          // The counter runs one past the last address so the final fill write
          // is still issued from FILL and IDLE begins with mem_we low.
          if (r_cnt != TOTAL) begin
            r_we_p2   <= 1'b1;
            r_addr_p2 <= r_cnt;
            r_data_p2 <= r_fill_color;
            r_cnt     <= r_cnt + 19'd1;
          end else begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_writer.sv
// tb_fb_writer -- bench for fb_writer. A queue of expected framebuffer events
// (pixel write, dropped request, fill write) is built from the request and fill
// rules; a negedge monitor compares every mem_we / err_oob cycle against it.
module tb_fb_writer;
  localparam int H   = 640;
  localparam int VR  = 24;
  localparam int TOT = H * VR;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fb_writer_if bus();

  fb_writer #(.H_RES(H), .V_RES(VR), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit oob;
    bit fill;
    int addr;
    int data;
    int acc;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  n_tests = 0, n_fail = 0;
  int  cyc = 0, run_len = 0, max_run = 0, last_lat = -1, last_addr = -1;
  int  n_we = 0, n_oob = 0, fill_viol = 0, stall_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_we) begin
        n_we++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
        last_addr = int'(bus.mem_addr);
        if (exp_q.size() == 0) check("unexp_we", 32'(bus.mem_we), 0);
        else begin
          mon_e = exp_q.pop_front();
          check("we_for_oob", 32'(mon_e.oob), 0);
          check("addr", 32'(bus.mem_addr), mon_e.addr);
          check("data", 32'(bus.mem_data), mon_e.data);
          if (mon_e.fill && (bus.req_ready !== 1'b0 || bus.busy !== 1'b1)) fill_viol++;
          if (mon_e.acc >= 0) last_lat = cyc - mon_e.acc;
        end
      end else run_len = 0;
      if (bus.err_oob) begin
        n_oob++;
        check("oob_with_we", 32'(bus.mem_we), 0);
        if (exp_q.size() == 0) check("unexp_oob", 32'(bus.err_oob), 0);
        else begin
          mon_e = exp_q.pop_front();
          check("oob_expected", 32'(mon_e.oob), 1);
          if (mon_e.acc >= 0) last_lat = cyc - mon_e.acc;
        end
      end
    end else run_len = 0;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=%0d exp=%0d", cyc, 0);
    $fatal(1, "watchdog");
  end

  task automatic push_px(input int x, input int y, input int c);
    ev_t e;
    e.oob  = (x >= H) || (y >= VR);
    e.fill = 1'b0;
    e.addr = y * H + x;
    e.data = c;
    e.acc  = cyc;
    exp_q.push_back(e);
  endtask

  task automatic push_fill(input int col);
    ev_t e;
    for (int a = 0; a < TOT; a++) begin
      e.oob = 1'b0; e.fill = 1'b1; e.addr = a; e.data = col; e.acc = -1;
      exp_q.push_back(e);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 with req_valid still high.
  task automatic send(input int x, input int y, input int c);
    int tries = 0;
    bus.req_valid = 1'b1;
    bus.req_x     = 10'(x);
    bus.req_y     = 9'(y);
    bus.req_color = 8'(c);
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && tries < 50) begin
      tries++;
      stall_cnt++;
      @(negedge clk);
    end
    if (bus.req_ready === 1'b1) push_px(x, y, c);
    else check("send_timeout", 32'(bus.req_ready), 1);
    @(posedge clk); #1;
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while ((exp_q.size() != 0 || bus.busy !== 1'b0) && t < budget) begin
      @(negedge clk); #1;
      t++;
    end
    check("drain_in_budget", 32'(t < budget), 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_fill_done(input int budget);
    int t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(negedge clk); #1;
      t++;
    end
    check("fill_in_budget", 32'(t < budget), 1);
    @(negedge clk); #1;
    check("post_fill_busy", 32'(bus.busy), 0);
    check("post_fill_ready", 32'(bus.req_ready), 1);
    check("post_fill_we", 32'(bus.mem_we), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n0, o0, t;
    bus.req_valid = 1'b0; bus.req_x = '0; bus.req_y = '0; bus.req_color = '0;
    bus.fill_start = 1'b0; bus.fill_color = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_oob", 32'(bus.err_oob), 0);
    check("rst_we", 32'(bus.mem_we), 0);
    check("rst_addr", 32'(bus.mem_addr), 0);
    check("rst_data", 32'(bus.mem_data), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(bus.req_ready), 1);
    @(posedge clk); #1;

    // Single write into an idle block.
    n0 = n_we;
    send(5, 2, 8'hE0);
    bus.req_valid = 1'b0;
    drain(50);
    check("single_count", 32'(n_we - n0), 1);
    check("single_addr", 32'(last_addr), 1285);
    check("single_latency", 32'(last_lat), 3);
    check("single_busy", 32'(bus.busy), 0);

    // Eight back-to-back requests.
    max_run = 0; stall_cnt = 0;
    for (int i = 0; i < 8; i++) send(i * 37 + 3, i + 1, i * 29 + 1);
    bus.req_valid = 1'b0;
    drain(60);
    check("burst_stalls", 32'(stall_cnt), 0);
    check("burst_run", 32'(max_run), 8);

    // Out-of-range drops and the last in-range pixel.
    n0 = n_we; o0 = n_oob;
    send(H, 0, 8'h11);
    bus.req_valid = 1'b0;
    drain(50);
    check("oobx_pulses", 32'(n_oob - o0), 1);
    check("oobx_no_we", 32'(n_we - n0), 0);
    check("oobx_latency", 32'(last_lat), 3);
    o0 = n_oob;
    send(0, VR, 8'h12);
    bus.req_valid = 1'b0;
    drain(50);
    check("ooby_pulses", 32'(n_oob - o0), 1);
    send(H - 1, VR - 1, 8'h22);
    bus.req_valid = 1'b0;
    drain(50);
    check("last_pixel_addr", 32'(last_addr), TOT - 1);

    // Randomised request stream with idle gaps.
    stall_cnt = 0;
    for (int i = 0; i < 80; i++) begin
      t = $urandom_range(0, 3);
      if (t == 0) begin
        bus.req_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send($urandom_range(0, H + 20), $urandom_range(0, VR + 2), $urandom_range(0, 255));
    end
    bus.req_valid = 1'b0;
    drain(200);
    check("rand_stalls", 32'(stall_cnt), 0);

    // Full-frame clear, with a second fill_start mid-fill that must be ignored.
    max_run = 0; fill_viol = 0;
    bus.fill_start = 1'b1; bus.fill_color = 8'h1C;
    @(negedge clk);
    push_fill(8'h1C);
    @(posedge clk); #1;
    bus.fill_start = 1'b0;
    check("fill_ready_drop", 32'(bus.req_ready), 0);
    check("fill_busy", 32'(bus.busy), 1);
    repeat (100) @(posedge clk);
    #1;
    bus.fill_start = 1'b1; bus.fill_color = 8'h03;
    @(posedge clk); #1;
    bus.fill_start = 1'b0;
    wait_fill_done(TOT + 200);
    check("fill_run", 32'(max_run), TOT);
    check("fill_ready_busy", 32'(fill_viol), 0);

    // Pixel and fill_start in the same cycle: pixel is written first.
    bus.req_valid = 1'b1; bus.req_x = 10'd1; bus.req_y = 9'd0; bus.req_color = 8'hFF;
    bus.fill_start = 1'b1; bus.fill_color = 8'h5A;
    @(negedge clk);
    check("combo_ready", 32'(bus.req_ready), 1);
    if (bus.req_ready === 1'b1) push_px(1, 0, 8'hFF);
    push_fill(8'h5A);
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.fill_start = 1'b0;
    wait_fill_done(TOT + 200);

    // Reset in the middle of a fill.
    bus.fill_start = 1'b1; bus.fill_color = 8'h66;
    @(negedge clk);
    push_fill(8'h66);
    @(posedge clk); #1;
    bus.fill_start = 1'b0;
    t = 0;
    while (!(bus.mem_we === 1'b1 && bus.mem_addr === 19'd1000) && t < 3000) begin
      @(negedge clk); #1;
      t++;
    end
    check("reach_1000", 32'(t < 3000), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    @(negedge clk);
    check("abort_we", 32'(bus.mem_we), 0);
    check("abort_addr", 32'(bus.mem_addr), 0);
    check("abort_data", 32'(bus.mem_data), 0);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_oob", 32'(bus.err_oob), 0);
    check("abort_ready", 32'(bus.req_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    n0 = n_we;
    send(7, 3, 8'hAA);
    bus.req_valid = 1'b0;
    drain(50);
    check("post_rst_count", 32'(n_we - n0), 1);
    check("post_rst_addr", 32'(last_addr), 1927);
    check("post_rst_latency", 32'(last_lat), 3);

    repeat (10) @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
